keypad_entry: RTL

- Input-side counterpart of seg_drive: instead of scanning digits out, it scans a 4x4 matrix keypad in.
- Drives one keypad column low at a time and samples the rows.
- Debounces over whole scan frames and emits one event per key press.
- Maintains a 4-digit BCD entry buffer (16 bits, same format seg_drive consumes) for presetting timer/data_control values.

---
 rtl/keypad_pkg.sv | 55 +++++
 rtl/keypad_frame_scan.sv | 116 +++++++++++
 rtl/keypad_entry.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/keypad_pkg.sv
// Shared types, key position codes and the key-value lookup for the keypad entry block.
package keypad_pkg;

  localparam int unsigned CODE_W = 4;
  localparam int unsigned DATA_W = 16;
  localparam int unsigned CNT_W  = 4;

  // Position codes are row*4 + col, rows top to bottom, columns left to right.
  localparam logic [CODE_W-1:0] KEY_1    = 4'd0;
  localparam logic [CODE_W-1:0] KEY_2    = 4'd1;
  localparam logic [CODE_W-1:0] KEY_3    = 4'd2;
  localparam logic [CODE_W-1:0] KEY_A    = 4'd3;
  localparam logic [CODE_W-1:0] KEY_4    = 4'd4;
  localparam logic [CODE_W-1:0] KEY_5    = 4'd5;
  localparam logic [CODE_W-1:0] KEY_6    = 4'd6;
  localparam logic [CODE_W-1:0] KEY_B    = 4'd7;
  localparam logic [CODE_W-1:0] KEY_7    = 4'd8;
  localparam logic [CODE_W-1:0] KEY_8    = 4'd9;
  localparam logic [CODE_W-1:0] KEY_9    = 4'd10;
  localparam logic [CODE_W-1:0] KEY_C    = 4'd11;
  localparam logic [CODE_W-1:0] KEY_STAR = 4'd12;
  localparam logic [CODE_W-1:0] KEY_0    = 4'd13;
  localparam logic [CODE_W-1:0] KEY_HASH = 4'd14;
  localparam logic [CODE_W-1:0] KEY_D    = 4'd15;

  typedef enum logic [1:0] {FRAME_NONE, FRAME_SINGLE, FRAME_MULTI} frame_kind_e;
  typedef enum logic [1:0] {ST_IDLE, ST_DEBOUNCE, ST_HELD, ST_RELEASE} state_e;

  typedef struct packed {
    logic       is_digit;
    logic [3:0] digit;
  } key_val_t;

  // Map a position code to its decimal value; non-digit keys report is_digit=0.
  function automatic key_val_t key_value(input logic [CODE_W-1:0] code);
    key_val_t v;
    v = '0;
    v.is_digit = 1'b1;
    case (code)
      KEY_0:   v.digit = 4'd0;
      KEY_1:   v.digit = 4'd1;
      KEY_2:   v.digit = 4'd2;
      KEY_3:   v.digit = 4'd3;
      KEY_4:   v.digit = 4'd4;
      KEY_5:   v.digit = 4'd5;
      KEY_6:   v.digit = 4'd6;
      KEY_7:   v.digit = 4'd7;
      KEY_8:   v.digit = 4'd8;
      KEY_9:   v.digit = 4'd9;
      default: v.is_digit = 1'b0;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/keypad_frame_scan.sv
// Column scanner: synchronizes rows, drives one column low at a time and classifies each 4-column frame.
module keypad_frame_scan
  import keypad_pkg::*;
#(
  parameter int unsigned SCAN_DIV = 50000
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [3:0]        i_row,
  output logic [3:0]        o_col,
  output logic              o_frame_done,
  output frame_kind_e       o_frame_kind,
  output logic [CODE_W-1:0] o_frame_code
);

  localparam int unsigned DIV_W = $clog2(SCAN_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);

  logic [3:0]        row_s1_q, row_s1_d, row_s2_q, row_s2_d;
  logic [DIV_W-1:0]  div_q, div_d;
  logic [1:0]        col_idx_q, col_idx_d;
  logic [3:0]        col_q, col_d;
  logic [1:0]        hits_q, hits_d;
  logic [CODE_W-1:0] code_q, code_d;
  logic              done_q, done_d;
  frame_kind_e       kind_q, kind_d;
  logic [CODE_W-1:0] fcode_q, fcode_d;

  logic [1:0]        col_hits;
  logic [1:0]        col_row;
  logic [2:0]        hit_sum;
  logic [1:0]        hits_new;
  logic [CODE_W-1:0] code_new;

  // Next-state: synchronizer shift, divider, column rotation and hit accumulation (hits saturate at 2 = multi).
  always_comb begin
    row_s1_d  = i_row;
    row_s2_d  = row_s1_q;
    div_d     = div_q;
    col_idx_d = col_idx_q;
    col_d     = col_q;
    hits_d    = hits_q;
    code_d    = code_q;
    done_d    = 1'b0;
    kind_d    = kind_q;
    fcode_d   = fcode_q;
    col_hits  = 2'd0;
    col_row   = 2'd0;

    for (int r = 0; r < 4; r++) begin
      if (!row_s2_q[r]) begin
        if (col_hits != 2'd2) col_hits = col_hits + 2'd1;
        col_row = 2'(r);
      end
    end

    hit_sum  = {1'b0, hits_q} + {1'b0, col_hits};
    hits_new = (hit_sum >= 3'd2) ? 2'd2 : hit_sum[1:0];
    code_new = (col_hits == 2'd1 && hits_q == 2'd0) ? {col_row, col_idx_q} : code_q;

    if (div_q == DIV_LAST) begin
      div_d     = '0;
      col_idx_d = col_idx_q + 2'd1;
      col_d     = {col_q[2:0], col_q[3]};
      if (col_idx_q == 2'd3) begin
        done_d  = 1'b1;
        fcode_d = code_new;
        case (hits_new)
          2'd0:    kind_d = FRAME_NONE;
          2'd1:    kind_d = FRAME_SINGLE;
          default: kind_d = FRAME_MULTI;
        endcase
        hits_d = 2'd0;
        code_d = '0;
      end else begin
        hits_d = hits_new;
        code_d = code_new;
      end
    end else begin
      div_d = div_q + DIV_W'(1);
    end
  end

  // State registers with synchronous reset; reset discards any partial frame.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      row_s1_q  <= 4'hF;
      row_s2_q  <= 4'hF;
      div_q     <= '0;
      col_idx_q <= 2'd0;
      col_q     <= 4'b1110;
      hits_q    <= 2'd0;
      code_q    <= '0;
      done_q    <= 1'b0;
      kind_q    <= FRAME_NONE;
      fcode_q   <= '0;
    end else begin
      row_s1_q  <= row_s1_d;
      row_s2_q  <= row_s2_d;
      div_q     <= div_d;
      col_idx_q <= col_idx_d;
      col_q     <= col_d;
      hits_q    <= hits_d;
      code_q    <= code_d;
      done_q    <= done_d;
      kind_q    <= kind_d;
      fcode_q   <= fcode_d;
    end
  end

  assign o_col        = col_q;
  assign o_frame_done = done_q;
  assign o_frame_kind = kind_q;
  assign o_frame_code = fcode_q;

endmodule

// File: rtl/keypad_entry.sv
// 4x4 keypad entry: frame-level debounce FSM, press events and a 4-digit BCD entry buffer.
module keypad_entry
  import keypad_pkg::*;
#(
  parameter int unsigned SCAN_DIV        = 50000,
  parameter int unsigned DEBOUNCE_FRAMES = 4
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [3:0]  i_row,
  output logic [3:0]  o_col,
  output logic        o_key_valid,
  output logic [3:0]  o_key_code,
  output logic        o_key_down,
  output logic [15:0] o_data
);

  localparam logic [CNT_W-1:0] DF_CNT = CNT_W'(DEBOUNCE_FRAMES);

  logic              frame_done;
  frame_kind_e       frame_kind;
  logic [CODE_W-1:0] frame_code;

  state_e            state_q, state_d;
  logic [CODE_W-1:0] cand_q, cand_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              valid_q, valid_d;
  logic [CODE_W-1:0] key_code_q, key_code_d;
  logic              down_q, down_d;
  logic [DATA_W-1:0] data_q, data_d;

  logic              single;
  logic              accept;
  logic [CODE_W-1:0] acc_code;
  logic [CNT_W-1:0]  cnt_inc;
  key_val_t          kv;

  keypad_frame_scan #(
    .SCAN_DIV(SCAN_DIV)
  ) u_scan (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_row       (i_row),
    .o_col       (o_col),
    .o_frame_done(frame_done),
    .o_frame_kind(frame_kind),
    .o_frame_code(frame_code)
  );

  // Next-state: per-frame debounce FSM plus accept-time update of code and BCD buffer.
  always_comb begin
    state_d    = state_q;
    cand_d     = cand_q;
    cnt_d      = cnt_q;
    valid_d    = 1'b0;
    key_code_d = key_code_q;
    data_d     = data_q;
    accept     = 1'b0;
    acc_code   = cand_q;
    single     = (frame_kind == FRAME_SINGLE);
    cnt_inc    = cnt_q + CNT_W'(1);

    if (frame_done) begin
      case (state_q)
        ST_IDLE: begin
          if (single) begin
            cand_d   = frame_code;
            acc_code = frame_code;
            cnt_d    = CNT_W'(1);
            if (DF_CNT == CNT_W'(1)) begin
              accept  = 1'b1;
              cnt_d   = '0;
              state_d = ST_HELD;
            end else begin
              state_d = ST_DEBOUNCE;
            end
          end
        end
        ST_DEBOUNCE: begin
          if (single && frame_code == cand_q) begin
            cnt_d = cnt_inc;
            if (cnt_inc == DF_CNT) begin
              accept  = 1'b1;
              cnt_d   = '0;
              state_d = ST_HELD;
            end
          end else begin
            cnt_d   = '0;
            state_d = ST_IDLE;
          end
        end
        ST_HELD: begin
          if (!single) begin
            if (DF_CNT == CNT_W'(1)) begin
              cnt_d   = '0;
              state_d = ST_IDLE;
            end else begin
              cnt_d   = CNT_W'(1);
              state_d = ST_RELEASE;
            end
          end
        end
        default: begin
          if (!single) begin
            cnt_d = cnt_inc;
            if (cnt_inc == DF_CNT) begin
              cnt_d   = '0;
              state_d = ST_IDLE;
            end
          end else begin
            cnt_d   = '0;
            state_d = ST_HELD;
          end
        end
      endcase
    end

    down_d = (state_d == ST_HELD) || (state_d == ST_RELEASE);

    kv = key_value(acc_code);
    if (accept) begin
      valid_d    = 1'b1;
      key_code_d = acc_code;
      if (acc_code == KEY_STAR) begin
        data_d = '0;
      end else if (acc_code == KEY_HASH) begin
        data_d = {4'h0, data_q[DATA_W-1:4]};
      end else if (kv.is_digit) begin
        data_d = {data_q[DATA_W-5:0], kv.digit};
      end
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q    <= ST_IDLE;
      cand_q     <= '0;
      cnt_q      <= '0;
      valid_q    <= 1'b0;
      key_code_q <= '0;
      down_q     <= 1'b0;
      data_q     <= '0;
    end else begin
      state_q    <= state_d;
      cand_q     <= cand_d;
      cnt_q      <= cnt_d;
      valid_q    <= valid_d;
      key_code_q <= key_code_d;
      down_q     <= down_d;
      data_q     <= data_d;
    end
  end

  assign o_key_valid = valid_q;
  assign o_key_code  = key_code_q;
  assign o_key_down  = down_q;
  assign o_data      = data_q;

endmodule
